// File: rtl/fifo_rd_ctrl_if.sv
// Handshake bundle between fifo_rd_ctrl, the fifo_mem read port and the downstream consumer.
// master = controller side, slave = FIFO/consumer side.
interface fifo_rd_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  fifo_threshold;
  logic                  fifo_rd;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_data, fifo_empty, fifo_threshold, m_ready,
    output fifo_rd, m_valid, m_data
  );

  modport slave (
    output fifo_data, fifo_empty, fifo_threshold, m_ready,
    input  fifo_rd, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Burst drain controller for fifo_mem: pulls words on threshold or idle timeout and
// presents them on a valid/ready stream through a 2-entry buffer.
module fifo_rd_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned IDLE_WAIT  = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  fifo_rd_ctrl_if.master       bus,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic                 busy
);

  localparam int unsigned BurstW = $clog2(BURST_LEN + 1);
  localparam int unsigned WaitW  = $clog2(IDLE_WAIT + 1);

  typedef enum logic [1:0] {StIdle, StDrain, StFlush} state_e;

  state_e                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [BurstW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [WaitW-1:0]      wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0]  rd_count_q;
  logic                  valid, pop, push, rd;
  logic [1:0]            credit_used;

  assign valid = (occ_q != 2'd0);
  assign pop   = valid && bus.m_ready;
  // The word read last cycle is on fifo_data now.
  assign push  = inflight_q;

  // Entries held plus the one in flight, minus the one leaving this cycle, must leave room.
  assign credit_used = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  assign rd = (state_q == StDrain) && !bus.fifo_empty && (credit_used < 2'd2);

  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = bus.fifo_data;
        else               buf1_d = bus.fifo_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = bus.fifo_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = bus.fifo_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      StIdle: begin
        if (!enable) begin
          wait_cnt_d = '0;
        end else if (bus.fifo_threshold) begin
          state_d = StDrain;
        end else if (bus.fifo_empty) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WaitW'(IDLE_WAIT)) begin
          state_d = StDrain;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StDrain: begin
        if (rd) burst_cnt_d = burst_cnt_q + BurstW'(1);
        if ((rd && burst_cnt_q == BurstW'(BURST_LEN - 1)) || bus.fifo_empty || !enable) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (!inflight_q) begin
          state_d     = StIdle;
          burst_cnt_d = '0;
          wait_cnt_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      burst_cnt_q <= '0;
      wait_cnt_q  <= '0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      inflight_q  <= rd;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      burst_cnt_q <= burst_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      rd_count_q  <= rd_count_q + {{(CNT_WIDTH - 1){1'b0}}, pop};
    end
  end

  assign bus.fifo_rd = rd;
  assign bus.m_valid = valid;
  assign bus.m_data  = buf0_q;
  assign rd_count    = rd_count_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural fifo_mem model, stream logger and directed plus
// randomized scenarios scored against the words pushed into the FIFO.
module tb_fifo_rd_ctrl;
  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] rd_count;
  logic          busy;

  fifo_rd_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_ctrl #(
    .DATA_WIDTH(DW),
    .BURST_LEN (4),
    .IDLE_WAIT (8),
    .CNT_WIDTH (CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .bus     (bus),
    .rd_count(rd_count),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // FIFO model: pushes written by the stimulus, pops on fifo_rd with one-cycle data latency.
  logic [DW-1:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always @(posedge clk) begin
    if (bus.fifo_rd && !bus.fifo_empty) begin
      bus.fifo_data  <= mem[rd_ptr];
      rd_ptr         <= rd_ptr + 1;
      bus.fifo_empty <= (rd_ptr + 1 == wr_ptr);
    end else begin
      bus.fifo_empty <= (rd_ptr == wr_ptr);
    end
  end

  // Stream logger, sampled mid-cycle.
  int            cyc = 0;
  int            rd_pulses = 0;
  int            delivered = 0;
  int            stall_viol = 0;
  int            rd_cyc [0:4095];
  int            got_cyc [0:4095];
  logic [DW-1:0] got [0:4095];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (bus.fifo_rd) begin
        rd_cyc[rd_pulses % 4096] <= cyc;
        rd_pulses <= rd_pulses + 1;
      end
      if (bus.m_valid && bus.m_ready) begin
        got[delivered % 4096]     <= bus.m_data;
        got_cyc[delivered % 4096] <= cyc;
        delivered <= delivered + 1;
      end
      if (prev_stall && !(bus.m_valid && bus.m_data == prev_data)) stall_viol <= stall_viol + 1;
      prev_stall <= bus.m_valid && !bus.m_ready;
      prev_data  <= bus.m_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_seq(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      mem[wr_ptr] = DW'(first + k);
      wr_ptr++;
    end
  endtask

  task automatic wait_busy(input logic val, input string tag);
    int i = 0;
    while (busy !== val && i < 200) begin
      tick(1);
      i++;
    end
    check(tag, busy, val);
  endtask

  task automatic drain_all(input string tag);
    int   i = 0;
    logic quiet = 1'b0;
    while (!quiet && i < 400) begin
      tick(1);
      i++;
      quiet = (rd_ptr == wr_ptr) && !busy && !bus.m_valid;
    end
    check(tag, quiet, 1);
  endtask

  task automatic check_got(input string tag, input int d0, input int n, input int first);
    for (int k = 0; k < n; k++) check(tag, got[(d0 + k) % 4096], first + k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0, c0, n, i, n_push;
    logic [DW-1:0] exp_w [0:4095];
    logic [DW-1:0] v;

    bus.fifo_threshold = 1'b0;
    bus.m_ready        = 1'b0;
    tick(3);
    check("rst_fifo_rd", bus.fifo_rd, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(2);

    // Threshold burst: 4 reads, then a second burst, then the rest by timeout.
    enable = 1'b1;
    bus.m_ready = 1'b1;
    bus.fifo_threshold = 1'b1;
    p0 = rd_pulses;
    d0 = delivered;
    push_seq(1, 10);
    wait_busy(1, "t1_busy_rise");
    bus.fifo_threshold = 1'b0;
    wait_busy(0, "t1_busy_fall");
    check("t1_reads", rd_pulses - p0, 4);
    check("t1_rd_consecutive", rd_cyc[p0 + 3] - rd_cyc[p0], 3);
    check("t1_latency", got_cyc[d0] - rd_cyc[p0], 2);
    check("t1_data_consecutive", got_cyc[d0 + 3] - got_cyc[d0], 3);
    check_got("t1_data", d0, 4, 1);
    check("t1_rd_count", rd_count, 4);
    bus.fifo_threshold = 1'b1;
    wait_busy(1, "t1b_busy_rise");
    bus.fifo_threshold = 1'b0;
    wait_busy(0, "t1b_busy_fall");
    check("t1b_reads", rd_pulses - p0, 8);
    check_got("t1b_data", d0 + 4, 4, 5);
    check("t1b_rd_count", rd_count, 8);
    drain_all("t1c_drain");
    check_got("t1c_data", d0 + 8, 2, 9);
    check("t1c_rd_count", rd_count, 10);

    // Timeout: single word, threshold low.
    tick(3);
    c0 = cyc;
    p0 = rd_pulses;
    d0 = delivered;
    mem[wr_ptr] = 16'h00AB;
    wr_ptr++;
    wait_busy(1, "t2_busy_rise");
    wait_busy(0, "t2_busy_fall");
    check("t2_reads", rd_pulses - p0, 1);
    check("t2_rd_after_empty_fall", rd_cyc[p0] - (c0 + 1), 9);
    check("t2_data", got[d0], 16'h00AB);
    check("t2_rd_count", rd_count, 11);

    // Backpressure: consumer stalled, only two reads fit.
    tick(2);
    bus.m_ready = 1'b0;
    bus.fifo_threshold = 1'b1;
    p0 = rd_pulses;
    d0 = delivered;
    push_seq(1, 6);
    tick(12);
    check("t3_reads_stalled", rd_pulses - p0, 2);
    check("t3_m_valid", bus.m_valid, 1);
    check("t3_m_data_held", bus.m_data, 1);
    check("t3_busy", busy, 1);
    check("t3_none_delivered", delivered - d0, 0);
    bus.fifo_threshold = 1'b0;
    bus.m_ready = 1'b1;
    wait_busy(0, "t3_busy_fall");
    check("t3_reads", rd_pulses - p0, 4);
    check_got("t3_data", d0, 4, 1);
    drain_all("t3_drain");
    check_got("t3_tail", d0 + 4, 2, 5);
    check("t3_stall_stable", stall_viol, 0);

    // Disable after the second read.
    tick(2);
    bus.fifo_threshold = 1'b1;
    p0 = rd_pulses;
    d0 = delivered;
    push_seq(1, 8);
    n = 0;
    i = 0;
    while (n < 2 && i < 50) begin
      tick(1);
      i++;
      if (bus.fifo_rd) n++;
    end
    enable = 1'b0;
    bus.fifo_threshold = 1'b0;
    wait_busy(0, "t4_busy_fall");
    tick(12);
    check("t4_reads", rd_pulses - p0, 2);
    check("t4_idle_disabled", busy, 0);
    check("t4_delivered", delivered - d0, 2);
    check_got("t4_data", d0, 2, 1);
    check("t4_fifo_left", wr_ptr - rd_ptr, 6);
    enable = 1'b1;
    drain_all("t4_drain");
    check_got("t4_tail", d0 + 2, 6, 3);

    // Reset mid-burst drops everything.
    tick(2);
    bus.m_ready = 1'b0;
    bus.fifo_threshold = 1'b1;
    push_seq(16'h21, 4);
    wait_busy(1, "t6_busy_rise");
    tick(3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_fifo_rd", bus.fifo_rd, 0);
    check("t6_rst_m_valid", bus.m_valid, 0);
    check("t6_rst_m_data", bus.m_data, 0);
    check("t6_rst_rd_count", rd_count, 0);
    check("t6_rst_busy", busy, 0);
    wr_ptr = rd_ptr;
    bus.fifo_threshold = 1'b0;
    tick(3);
    rst_n = 1'b1;
    p0 = rd_pulses;
    tick(15);
    check("t6_no_rd_after_rst", rd_pulses - p0, 0);
    check("t6_idle_after_rst", busy, 0);

    // Drain to empty: burst ends on fifo_empty.
    bus.m_ready = 1'b1;
    bus.fifo_threshold = 1'b1;
    p0 = rd_pulses;
    d0 = delivered;
    push_seq(1, 3);
    wait_busy(1, "t5_busy_rise");
    bus.fifo_threshold = 1'b0;
    wait_busy(0, "t5_busy_fall");
    check("t5_reads", rd_pulses - p0, 3);
    check_got("t5_data", d0, 3, 1);
    check("t5_rd_count", rd_count, 3);

    // Randomized traffic: every pushed word must come out once, in order.
    d0 = delivered;
    n_push = 0;
    for (int c = 0; c < 400; c++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      bus.fifo_threshold = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 2) == 0) begin
        v = DW'($urandom);
        mem[wr_ptr] = v;
        wr_ptr++;
        exp_w[n_push] = v;
        n_push++;
      end
      tick(1);
    end
    bus.fifo_threshold = 1'b0;
    bus.m_ready = 1'b1;
    enable = 1'b1;
    drain_all("rnd_drain");
    check("rnd_count", delivered - d0, n_push);
    for (int k = 0; k < n_push; k++) check("rnd_word", got[(d0 + k) % 4096], exp_w[k]);
    check("rnd_rd_count", rd_count, 3 + n_push);
    check("rnd_stall_stable", stall_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side drain controller for `fifo_mem`. It pulls words out of the FIFO using the FIFO's `trans_read`/`empty_ind`/`threshold_ind` interface and presents them on a valid/ready stream with a 2-entry output buffer. Draining is done in bursts, triggered by the threshold flag or by an idle timeout. It sits between `fifo_mem` and the downstream consumer, which can stall it.

## Interface
- `DATA_WIDTH`, 16, word width; matches `fifo_mem.DATA_WIDTH`.
- `BURST_LEN`, 4, maximum FIFO reads issued per burst (≥1).
- `IDLE_WAIT`, 8, cycles a non-empty, sub-threshold FIFO waits before a burst starts (≥1).
- `CNT_WIDTH`, 16, width of the delivered-word counter.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  allows new bursts; deassertion ends the current burst.
- `fifo_data`  in  DATA_WIDTH  `fifo_mem.data_out`.
- `fifo_empty`  in  1  `fifo_mem.empty_ind`.
- `fifo_threshold`  in  1  `fifo_mem.threshold_ind`.
- `fifo_rd`  out  1  drives `fifo_mem.trans_read`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  DATA_WIDTH  output word.
- `rd_count`  out  CNT_WIDTH  words delivered; wraps modulo 2^CNT_WIDTH.
- `busy`  out  1  high when state ≠ IDLE.

## Operation
- FIFO contract: `fifo_data` holds the popped word in the cycle after the cycle in which `fifo_rd` was high and `fifo_empty` was low. `fifo_empty` updates in the cycle after the read.
- Internal state:
  - `occ` (0..2): buffer entries held.
  - `inflight` (0/1): a read was issued last cycle.
  - `pop` = `m_valid && m_ready`.
- `fifo_rd` is combinational: `fifo_rd = (state==DRAIN) && !fifo_empty && (occ + inflight - pop) < 2`. The buffer never overflows.
- Data flows into the buffer in FIFO order; `m_data` is the buffer head. `m_valid = (occ != 0)`.
- State machine:
  - **IDLE**
    - Requires `enable`.
    - `fifo_threshold` → DRAIN.
    - Otherwise, if `!fifo_empty`, the wait counter increments. When it reaches `IDLE_WAIT` → DRAIN.
    - `fifo_empty` or `!enable` clears the wait counter.
  - **DRAIN**
    - Each `fifo_rd` increments the burst counter.
    - → FLUSH when any of these holds: the counter reaches `BURST_LEN` (after the last read), or `fifo_empty`, or `!enable`.
    - A credit stall alone stays in DRAIN.
  - **FLUSH**
    - No reads are issued.
    - → IDLE when `inflight == 0`.
    - Burst counter and wait counter clear on IDLE entry.
- `m_valid`/`m_data` are independent of state. Buffered and in-flight words are always delivered, including after `enable` drops.
- Valid/ready rule: while `m_valid && !m_ready`, `m_data` is held stable and `m_valid` stays high.
- `rd_count` increments on each `pop`.
- Simultaneous push (in-flight capture) and pop in one cycle: `occ` is unchanged and order is preserved.

## Timing
- Reset values (asynchronous):
  - `fifo_rd`=0 (state IDLE), `m_valid`=0, `m_data`=0, `rd_count`=0, `busy`=0.
  - All counters, `occ` and `inflight` = 0.
- Reset mid-burst drops buffered and in-flight words.
- Read latency: `fifo_rd` in cycle t → word captured at the end of t+1 → `m_valid` in t+2 when the buffer was empty.
- Throughput: one word per cycle sustained while `m_ready`=1 and the FIFO is non-empty.
- `busy` rises the cycle after the DRAIN-triggering condition is sampled. It falls the cycle after FLUSH sees `inflight`=0.
- Threshold trigger: first `fifo_rd` one cycle after `fifo_threshold` is sampled high in IDLE.
- Timeout trigger: first `fifo_rd` `IDLE_WAIT`+1 cycles after `fifo_empty` falls (threshold low).

## Test plan
- **Reset:** assert `rst_n`=0 mid-run → all outputs 0 immediately. After release: no `fifo_rd` until a trigger occurs.
- **Threshold burst:** behavioural FIFO holds 0x0001..0x000A, `fifo_threshold`=1, `m_ready`=1.
  - `fifo_rd` is high for exactly 4 consecutive cycles.
  - `m_data` shows 1,2,3,4 on consecutive cycles starting 2 cycles after the first `fifo_rd`.
  - Then FLUSH → IDLE, and the next burst delivers 5..8.
  - `rd_count`=8 after the second burst.
- **Timeout:** 1 word (0x00AB), threshold low → `fifo_rd` pulses once, 9 cycles after empty falls. `m_data`=0x00AB. Then `fifo_empty` → FLUSH → IDLE.
- **Backpressure:** 6 words, threshold high, `m_ready`=0.
  - Exactly 2 `fifo_rd` pulses occur; `m_data`=1 is held.
  - Raising `m_ready` → 1,2,3,4 delivered with no loss or duplication.
- **Disable mid-burst:** drop `enable` after the 2nd `fifo_rd` → no further reads. Words 1,2 are still delivered, `busy` falls, and the FIFO retains the rest.
- **Drain to empty:** 3 words, threshold high → 3 reads, DRAIN exits on `fifo_empty`, output 1,2,3, `rd_count`=3.
